// File: rtl/spi_slave_if.sv
// SPI target pin and parallel-word bundle shared by the slave endpoint and its driver.
interface spi_slave_if #(
    parameter int unsigned WIDTH = 7
);
    logic             SCLK;
    logic             SS;
    logic             MOSI;
    logic             MISO;
    logic             miso_en;
    logic [WIDTH-1:0] tx_data;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;
    logic             frame_err;

    modport slave (
        input  SCLK, SS, MOSI, tx_data,
        output MISO, miso_en, rx_data, rx_valid, busy, frame_err
    );

    modport master (
        output SCLK, SS, MOSI, tx_data,
        input  MISO, miso_en, rx_data, rx_valid, busy, frame_err
    );
endinterface

// File: rtl/spi_slave.sv
// SPI mode-0 target: oversamples SCLK/SS/MOSI, deserialises MOSI words and
// serialises a reply word onto MISO, flagging completed and aborted words.
module spi_slave #(
    parameter int unsigned WIDTH       = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    spi_slave_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_prev;
    logic                   ss_prev;

    logic sclk_s;
    logic ss_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic ss_rise;
    logic ss_fall;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0] cnt,       cnt_d;
    logic [WIDTH-1:0] rx_sr,     rx_sr_d;
    logic [WIDTH-1:0] tx_sr,     tx_sr_d;
    logic             word_done, word_done_d;
    logic             miso_q,    miso_d;
    logic             miso_en_q, miso_en_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             busy_q,    busy_d;
    logic             frame_err_q, frame_err_d;

    // Synchronisers plus one extra stage for edge detection; reset to idle pin levels
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0],   bus.SS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.MOSI};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise =  sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s &  sclk_prev;
    assign ss_rise   =  ss_s   & ~ss_prev;
    assign ss_fall   = ~ss_s   &  ss_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (ss_fall) state_nxt = SHIFT;
            SHIFT:   if (ss_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        cnt_d       = cnt;
        rx_sr_d     = rx_sr;
        tx_sr_d     = tx_sr;
        word_done_d = 1'b0;
        miso_d      = miso_q;
        miso_en_d   = miso_en_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        busy_d      = (state_nxt == SHIFT);

        // Assembled word is published the cycle after its final bit was shifted in
        if (word_done) begin
            rx_data_d  = rx_sr;
            rx_valid_d = 1'b1;
        end

        unique case (state)
            IDLE: begin
                miso_d    = 1'b0;
                miso_en_d = 1'b0;
                if (ss_fall) begin
                    tx_sr_d   = bus.tx_data;
                    miso_d    = bus.tx_data[WIDTH-1];
                    miso_en_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    // Deselect beats a coincident SCLK rise; partial word is dropped
                    miso_d      = 1'b0;
                    miso_en_d   = 1'b0;
                    cnt_d       = '0;
                    frame_err_d = (cnt != '0);
                end else if (sclk_rise) begin
                    rx_sr_d = {rx_sr[WIDTH-2:0], mosi_s};
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        cnt_d       = '0;
                        word_done_d = 1'b1;
                        tx_sr_d     = bus.tx_data;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    // A fall with count zero follows a completed word: present the fresh MSB
                    if (cnt == '0) begin
                        miso_d = tx_sr[WIDTH-1];
                    end else begin
                        miso_d  = tx_sr[WIDTH-2];
                        tx_sr_d = {tx_sr[WIDTH-2:0], 1'b0};
                    end
                end
            end
            default: begin
                miso_d    = 1'b0;
                miso_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rx_sr       <= '0;
            tx_sr       <= '0;
            word_done   <= 1'b0;
            miso_q      <= 1'b0;
            miso_en_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cnt         <= cnt_d;
            rx_sr       <= rx_sr_d;
            tx_sr       <= tx_sr_d;
            word_done   <= word_done_d;
            miso_q      <= miso_d;
            miso_en_q   <= miso_en_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.MISO      = miso_q;
    assign bus.miso_en   = miso_en_q;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.busy      = busy_q;
    assign bus.frame_err = frame_err_q;
endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: an SPI master model drives frames while scoreboard
// monitors check received words, abort pulses and MISO bits.
module tb_spi_slave;
    localparam int unsigned W = 7;

    typedef struct packed {
        logic         is_err;
        logic [W-1:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst;

    ev_t  exp_q[$];
    logic miso_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    spi_slave_if #(.WIDTH(W)) bus ();

    spi_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Word and abort events from the DUT are matched in order against expectations
    task automatic monitor_rx();
        ev_t ev;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && (bus.rx_valid === 1'b1 || bus.frame_err === 1'b1)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'({bus.rx_valid, bus.frame_err}), 32'(0));
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.is_err)
                        check("abort_pulse", 32'({bus.rx_valid, bus.frame_err}), 32'(2'b01));
                    else
                        check("rx_word", 32'({bus.rx_valid, bus.frame_err, bus.rx_data}),
                              32'({2'b10, ev.data}));
                end
            end
        end
    endtask

    // The master samples MISO on each SCLK rise while selected
    task automatic monitor_miso();
        logic e;
        forever begin
            @(posedge bus.SCLK);
            if (rst === 1'b0 && bus.SS === 1'b0) begin
                if (miso_q.size() == 0) begin
                    check("miso_unexpected_rise", 32'(miso_q.size()), 32'(1));
                end else begin
                    e = miso_q.pop_front();
                    check("miso_bit", 32'(bus.MISO), 32'(e));
                end
            end
        end
    endtask

    task automatic send_bit(input logic b, input logic exp_miso, input int half);
        bus.MOSI = b;
        miso_q.push_back(exp_miso);
        repeat (half) @(negedge clk);
        bus.SCLK = 1'b1;
        repeat (half) @(negedge clk);
        bus.SCLK = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic [W-1:0] tx, input int half);
        ev_t ev;
        ev.is_err = 1'b0;
        ev.data   = w;
        exp_q.push_back(ev);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i], tx[i], half);
    endtask

    task automatic select_frame(input logic [W-1:0] tx);
        bus.tx_data = tx;
        @(negedge clk);
        bus.SS = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic deselect();
        repeat (4) @(negedge clk);
        bus.SS = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] tx;
        ev_t          ev;

        rst         = 1'b1;
        bus.SCLK    = 1'b0;
        bus.SS      = 1'b1;
        bus.MOSI    = 1'b0;
        bus.tx_data = '0;
        fork
            monitor_rx();
            monitor_miso();
        join_none

        repeat (3) @(negedge clk);
        check("reset_miso",    32'(bus.MISO),      32'(0));
        check("reset_miso_en", 32'(bus.miso_en),   32'(0));
        check("reset_rx_data", 32'(bus.rx_data),   32'(0));
        check("reset_pulses",  32'({bus.rx_valid, bus.frame_err}), 32'(0));
        check("reset_busy",    32'(bus.busy),      32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single word with busy and miso_en timing relative to SS edges
        bus.tx_data = 7'h2A;
        @(negedge clk);
        bus.SS = 1'b0;
        repeat (2) @(negedge clk);
        check("busy_before_sel", 32'(bus.busy), 32'(0));
        @(negedge clk);
        check("busy_after_sel",  32'(bus.busy),    32'(1));
        check("miso_en_sel",     32'(bus.miso_en), 32'(1));
        send_word(7'h55, 7'h2A, 4);
        repeat (4) @(negedge clk);
        bus.SS = 1'b1;
        repeat (2) @(negedge clk);
        check("busy_before_desel", 32'(bus.busy), 32'(1));
        @(negedge clk);
        check("busy_after_desel", 32'(bus.busy),    32'(0));
        check("miso_en_desel",    32'(bus.miso_en), 32'(0));
        check("miso_desel",       32'(bus.MISO),    32'(0));
        check("rx_hold_single",   32'(bus.rx_data), 32'(7'h55));
        repeat (4) @(negedge clk);

        // Back-to-back words under one SS assertion
        select_frame(7'h40);
        send_word(7'h7F, 7'h40, 4);
        send_word(7'h01, 7'h40, 4);
        deselect();
        check("rx_hold_b2b", 32'(bus.rx_data), 32'(7'h01));

        // Abort after three bits: rx_data must keep the last complete word
        select_frame(7'h13);
        send_word(7'h55, 7'h13, 4);
        deselect();
        select_frame(7'h6C);
        send_bit(1'b1, 1'b1, 4);
        send_bit(1'b0, 1'b1, 4);
        send_bit(1'b1, 1'b0, 4);
        repeat (4) @(negedge clk);
        ev.is_err = 1'b1;
        ev.data   = '0;
        exp_q.push_back(ev);
        bus.SS = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_miso_en", 32'(bus.miso_en), 32'(0));
        check("abort_rx_hold", 32'(bus.rx_data), 32'(7'h55));
        repeat (6) @(negedge clk);

        // SCLK and MOSI activity while deselected must be ignored
        for (int t = 0; t < 20; t++) begin
            bus.MOSI = 1'($urandom);
            bus.SCLK = ~bus.SCLK;
            repeat (4) begin
                @(negedge clk);
                check("idle_quiet", 32'({bus.busy, bus.miso_en, bus.frame_err, bus.rx_valid, bus.MISO}),
                      32'(0));
            end
        end
        repeat (6) @(negedge clk);

        // Reset in the middle of a word, then a clean frame
        tx = 7'($urandom);
        select_frame(tx);
        for (int i = W - 1; i >= W - 4; i--) send_bit(1'($urandom), tx[i], 4);
        repeat (2) @(negedge clk);
        rst    = 1'b1;
        bus.SS = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_outputs", 32'({bus.MISO, bus.miso_en, bus.rx_valid, bus.busy, bus.frame_err}),
              32'(0));
        check("rst_mid_rx_data", 32'(bus.rx_data), 32'(0));
        repeat (4) @(negedge clk);
        select_frame(tx);
        send_word(7'h33, tx, 4);
        deselect();
        check("rx_after_reset", 32'(bus.rx_data), 32'(7'h33));

        // Random frames at the fastest legal SCLK
        for (int f = 0; f < 100; f++) begin
            w  = 7'($urandom);
            tx = 7'($urandom);
            select_frame(tx);
            send_word(w, tx, 4);
            deselect();
            check("rx_random_hold", 32'(bus.rx_data), 32'(w));
        end

        repeat (20) @(negedge clk);
        check("events_drained", 32'(exp_q.size()),  32'(0));
        check("miso_drained",   32'(miso_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
